multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles FETCH/MEM waits on mem_ready before timeout (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst input 1: asynchronous, active-high reset.
REQ-005 SHALL have port opcode input 7: RISC-V opcode field from instruction register.
REQ-006 SHALL have port mem_ready input 1: memory completes current read/write this cycle.
REQ-007 SHALL have port trap_ack input 1: handler acknowledges trap.
REQ-008 SHALL have ports Regwrite, ALUsrc, Memread, Memwrite, Memtoreg, Branch, Jump, output 1 each: datapath controls.
REQ-009 SHALL have port ALUop output 2: 00 add, 01 branch compare, 10 funct-decoded.
REQ-010 SHALL have ports PCwrite, IRwrite, instr_done, trap, output 1 each.
REQ-011 SHALL have port retired_cnt output CNT_W: count of completed instructions.

Function
REQ-012 SHALL implement Moore FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs decoded from state and latched op_q only.
REQ-013 SHALL go IDLE -> FETCH on first clock after rst deasserts; all outputs 0 in IDLE.
REQ-014 SHALL in FETCH drive Memread=1; on mem_ready drive IRwrite=1, PCwrite=1 same cycle and go DECODE; else stay.
REQ-015 SHALL in DECODE capture opcode into op_q and go EXEC unconditionally.
REQ-016 SHALL in EXEC decode op_q: R-type 0110011 ALUop=10 ALUsrc=0 -> WB; I-type 0010011 ALUop=10 ALUsrc=1 -> WB; load 0000011/store 0100011 ALUop=00 ALUsrc=1 -> MEM; branch 1100011 ALUop=01 Branch=1 instr_done=1 -> FETCH; JAL 1101111/JALR 1100111 Jump=1 PCwrite=1 ALUsrc=(JALR) -> WB.
REQ-017 SHALL in MEM drive Memread=1 (load) or Memwrite=1 (store) until mem_ready; load -> WB; store -> FETCH with instr_done=1 in the mem_ready cycle.
REQ-018 SHALL in WB drive Regwrite=1, Memtoreg=1 only for load, instr_done=1, -> FETCH.
REQ-019 SHALL increment retired_cnt in every cycle instr_done=1, wrapping modulo 2^CNT_W.
REQ-020 SHALL reset wait counter on entry to FETCH/MEM and on mem_ready; mem_ready in the first wait cycle costs zero extra cycles.
REQ-021 SHALL never assert Memread and Memwrite together, nor Regwrite outside WB.
REQ-022 SHALL ignore opcode changes in all states except DECODE.

Reset
REQ-023 SHALL on rst high immediately (asynchronously) enter IDLE, clear op_q, wait counter, retired_cnt, trap; all outputs 0 within same cycle, including mid-MEM or mid-TRAP.

Configuration
REQ-024 SHALL with TRAP_EN defined: unknown op_q in EXEC, or wait counter reaching MEM_TIMEOUT without mem_ready, -> TRAP; TRAP drives trap=1, all other outputs 0, leaves to FETCH on trap_ack; no instr_done for trapped instruction.
REQ-025 SHALL with TRAP_EN undefined: unknown op_q in EXEC -> FETCH with instr_done=1 and no writes (NOP); no timeout, waits indefinitely; trap tied 0; TRAP state absent.

Verification
REQ-026 SHALL check R-type, mem_ready held 1: FETCH,DECODE,EXEC,WB; Regwrite=1 ALUop=10 in WB, instr_done 4th cycle after FETCH entry, retired_cnt 0->1.
REQ-027 SHALL check load with mem_ready low 3 cycles in MEM: Memread=1 for 4 MEM cycles, then WB with Regwrite=1 Memtoreg=1; 8 cycles FETCH-to-done.
REQ-028 SHALL check store then branch: Memwrite=1 only in MEM, Regwrite never 1; branch Branch=1 ALUop=01 in EXEC, retired_cnt +2.
REQ-029 SHALL check opcode 1111111 with TRAP_EN: trap=1 held until trap_ack pulse, retired_cnt unchanged; without TRAP_EN: instr_done=1, retired_cnt +1.
REQ-030 SHALL check TRAP_EN, MEM_TIMEOUT=15, mem_ready held 0 in FETCH: trap=1 after 15 wait cycles.
REQ-031 SHALL check rst pulse during MEM of load and CNT_W=4 wrap: outputs 0 immediately, IDLE then FETCH; 16 retirements return retired_cnt to 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit_if
//  Description : Bundle of instruction/memory handshake inputs and datapath
//                control outputs exchanged between the multicycle control
//                unit and the datapath.
//                  master : control unit side (drives controls, counter)
//                  slave  : datapath side (drives opcode, mem_ready, trap_ack)
//  Parameters  : CNT_W - width of retired_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             trap_ack;

    logic             Regwrite;
    logic             ALUsrc;
    logic             Memread;
    logic             Memwrite;
    logic             Memtoreg;
    logic             Branch;
    logic             Jump;
    logic [1:0]       ALUop;
    logic             PCwrite;
    logic             IRwrite;
    logic             instr_done;
    logic             trap;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  opcode, mem_ready, trap_ack,
        output Regwrite, ALUsrc, Memread, Memwrite, Memtoreg, Branch, Jump,
               ALUop, PCwrite, IRwrite, instr_done, trap, retired_cnt
    );

    modport slave (
        output opcode, mem_ready, trap_ack,
        input  Regwrite, ALUsrc, Memread, Memwrite, Memtoreg, Branch, Jump,
               ALUop, PCwrite, IRwrite, instr_done, trap, retired_cnt
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Multicycle RISC-V control FSM
//                (IDLE/FETCH/DECODE/EXEC/MEM/WB[/TRAP]) with retired-
//                instruction counter.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - asynchronous active-high reset
//                bus  - multicycle_control_unit_if.master
//                       in : opcode, mem_ready, trap_ack
//                       out: Regwrite, ALUsrc, Memread, Memwrite, Memtoreg,
//                            Branch, Jump, ALUop, PCwrite, IRwrite,
//                            instr_done, trap, retired_cnt
//  Parameters  : MEM_TIMEOUT - wait-cycle limit in FETCH/MEM (1..255)
//                CNT_W       - retired_cnt width
//  Config      : TRAP_EN - when defined, unknown opcodes and memory timeouts
//                enter TRAP; otherwise unknown opcodes retire as NOPs and
//                memory waits are unbounded.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input wire                         clk,
    input wire                         rst,
    multicycle_control_unit_if.master  bus
);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

`ifdef TRAP_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);
    logic [7:0] r_wait;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;
`endif

    state_t           r_state;
    logic [6:0]       r_op;
    logic [CNT_W-1:0] r_cnt;

    logic       w_regwrite, w_alusrc, w_memread, w_memwrite, w_memtoreg;
    logic       w_branch, w_jump, w_pcwrite, w_irwrite, w_done, w_trap;
    logic [1:0] w_aluop;
    logic       w_is_load;

    assign w_is_load = (r_op == c_op_load);

    // ------------------------------------------------------------------------
    // State, latched opcode, wait counter and retired counter.
    // The wait counter clears by default every cycle and only advances while
    // FETCH/MEM is stalled, so it is zero on every entry and after mem_ready.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
`ifdef TRAP_EN
            r_wait  <= '0;
`endif
        end else begin
            if (w_done)
                r_cnt <= r_cnt + CNT_W'(1);
`ifdef TRAP_EN
            r_wait <= '0;
`endif
            case (r_state)
                IDLE: r_state <= FETCH;

                FETCH: begin
                    if (bus.mem_ready)
                        r_state <= DECODE;
`ifdef TRAP_EN
                    else if (r_wait == c_wait_last)
                        r_state <= TRAP;
                    else
                        r_wait <= r_wait + 8'd1;
`endif
                end

                DECODE: begin
                    r_op    <= bus.opcode;
                    r_state <= EXEC;
                end

                EXEC: begin
                    case (r_op)
                        c_op_r, c_op_i, c_op_jal, c_op_jalr: r_state <= WB;
                        c_op_load, c_op_store:               r_state <= MEM;
                        c_op_branch:                         r_state <= FETCH;
`ifdef TRAP_EN
                        default:                             r_state <= TRAP;
`else
                        default:                             r_state <= FETCH;
`endif
                    endcase
                end

                MEM: begin
                    if (bus.mem_ready)
                        r_state <= w_is_load ? WB : FETCH;
`ifdef TRAP_EN
                    else if (r_wait == c_wait_last)
                        r_state <= TRAP;
                    else
                        r_wait <= r_wait + 8'd1;
`endif
                end

                WB: r_state <= FETCH;

`ifdef TRAP_EN
                TRAP: begin
                    if (bus.trap_ack)
                        r_state <= FETCH;
                end
`endif

                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode. Depends on state and r_op only, except for the
    // same-cycle handshake terms (IRwrite/PCwrite in FETCH and store
    // completion in MEM), which must respond to mem_ready in the cycle it
    // arrives. Being decoded from state, all outputs drop as soon as the
    // asynchronous reset forces IDLE.
    // ------------------------------------------------------------------------
    always_comb begin
        w_regwrite = 1'b0;
        w_alusrc   = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_branch   = 1'b0;
        w_jump     = 1'b0;
        w_aluop    = 2'b00;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_done     = 1'b0;
        w_trap     = 1'b0;

        case (r_state)
            FETCH: begin
                w_memread = 1'b1;
                if (bus.mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                end
            end

            EXEC: begin
                case (r_op)
                    c_op_r: w_aluop = 2'b10;
                    c_op_i: begin
                        w_aluop  = 2'b10;
                        w_alusrc = 1'b1;
                    end
                    c_op_load, c_op_store: w_alusrc = 1'b1;
                    c_op_branch: begin
                        w_aluop  = 2'b01;
                        w_branch = 1'b1;
                        w_done   = 1'b1;
                    end
                    c_op_jal: begin
                        w_jump    = 1'b1;
                        w_pcwrite = 1'b1;
                    end
                    c_op_jalr: begin
                        w_jump    = 1'b1;
                        w_pcwrite = 1'b1;
                        w_alusrc  = 1'b1;
                    end
`ifndef TRAP_EN
                    // unknown opcode retires as a NOP with no writes
                    default: w_done = 1'b1;
`else
                    default: ;
`endif
                endcase
            end

            MEM: begin
                if (w_is_load) begin
                    w_memread = 1'b1;
                end else begin
                    w_memwrite = 1'b1;
                    w_done     = bus.mem_ready;
                end
            end

            WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = w_is_load;
                w_done     = 1'b1;
                // keep the ALU function stable while the result is written
                if ((r_op == c_op_r) || (r_op == c_op_i))
                    w_aluop = 2'b10;
            end

`ifdef TRAP_EN
            TRAP: w_trap = 1'b1;
`endif

            default: ;
        endcase
    end

    assign bus.Regwrite    = w_regwrite;
    assign bus.ALUsrc      = w_alusrc;
    assign bus.Memread     = w_memread;
    assign bus.Memwrite    = w_memwrite;
    assign bus.Memtoreg    = w_memtoreg;
    assign bus.Branch      = w_branch;
    assign bus.Jump        = w_jump;
    assign bus.ALUop       = w_aluop;
    assign bus.PCwrite     = w_pcwrite;
    assign bus.IRwrite     = w_irwrite;
    assign bus.instr_done  = w_done;
    assign bus.trap        = w_trap;
    assign bus.retired_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Directed self-checking bench for multicycle_control_unit
//                (CNT_W=4, MEM_TIMEOUT=15). Follows TRAP_EN the same way
//                as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam logic [6:0] c_r     = 7'b0110011;
    localparam logic [6:0] c_load  = 7'b0000011;
    localparam logic [6:0] c_store = 7'b0100011;
    localparam logic [6:0] c_br    = 7'b1100011;
    localparam logic [6:0] c_jalr  = 7'b1100111;
    localparam logic [6:0] c_bad   = 7'b1111111;

    // {Regwrite,ALUsrc,Memread,Memwrite,Memtoreg,Branch,Jump,ALUop,PCwrite,IRwrite,instr_done,trap}
    localparam logic [12:0] c_none       = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] c_fetch_rdy  = 13'b0_0_1_0_0_0_0_00_1_1_0_0;
    localparam logic [12:0] c_memread    = 13'b0_0_1_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] c_exec_r     = 13'b0_0_0_0_0_0_0_10_0_0_0_0;
    localparam logic [12:0] c_wb_r       = 13'b1_0_0_0_0_0_0_10_0_0_1_0;
    localparam logic [12:0] c_exec_mem   = 13'b0_1_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] c_wb_load    = 13'b1_0_0_0_1_0_0_00_0_0_1_0;
    localparam logic [12:0] c_memwrite   = 13'b0_0_0_1_0_0_0_00_0_0_0_0;
    localparam logic [12:0] c_store_done = 13'b0_0_0_1_0_0_0_00_0_0_1_0;
    localparam logic [12:0] c_exec_br    = 13'b0_0_0_0_0_1_0_01_0_0_1_0;
    localparam logic [12:0] c_exec_jalr  = 13'b0_1_0_0_0_0_1_00_1_0_0_0;
    localparam logic [12:0] c_wb_jump    = 13'b1_0_0_0_0_0_0_00_0_0_1_0;
    localparam logic [12:0] c_exec_nop   = 13'b0_0_0_0_0_0_0_00_0_0_1_0;
    localparam logic [12:0] c_trap       = 13'b0_0_0_0_0_0_0_00_0_0_0_1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.CNT_W(4)) bus ();

    multicycle_control_unit #(
        .MEM_TIMEOUT (15),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [12:0] w_outs = {bus.Regwrite, bus.ALUsrc, bus.Memread, bus.Memwrite,
                          bus.Memtoreg, bus.Branch, bus.Jump, bus.ALUop,
                          bus.PCwrite, bus.IRwrite, bus.instr_done, bus.trap};

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_cnt;
    logic       pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, then check the
    // control vector and the retired counter for this cycle.
    task automatic cyc(input logic mr, input logic [6:0] op, input logic ack,
                       input string tag, input logic [12:0] exp);
        @(posedge clk);
        #1;
        if (pend) exp_cnt = exp_cnt + 4'd1;
        pend          = 1'b0;
        bus.mem_ready = mr;
        bus.opcode    = op;
        bus.trap_ack  = ack;
        #1;
        check(tag, {19'b0, w_outs}, {19'b0, exp});
        check({tag, "_cnt"}, {28'b0, bus.retired_cnt}, {28'b0, exp_cnt});
        pend = exp[1];
    endtask

    task automatic do_branch();
        cyc(1'b1, c_bad, 1'b0, "br_fetch",  c_fetch_rdy);
        cyc(1'b1, c_br,  1'b0, "br_decode", c_none);
        cyc(1'b1, c_bad, 1'b0, "br_exec",   c_exec_br);
    endtask

    initial begin
        bus.opcode    = c_bad;
        bus.mem_ready = 1'b0;
        bus.trap_ack  = 1'b0;
        exp_cnt       = 4'd0;
        pend          = 1'b0;
        rst           = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_outs", {19'b0, w_outs}, 32'd0);
        check("reset_cnt", {28'b0, bus.retired_cnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("idle_outs", {19'b0, w_outs}, 32'd0);

        // R-type, mem_ready held high; opcode garbage outside DECODE
        cyc(1'b1, c_bad, 1'b0, "r_fetch",  c_fetch_rdy);
        cyc(1'b1, c_r,   1'b0, "r_decode", c_none);
        cyc(1'b1, c_bad, 1'b0, "r_exec",   c_exec_r);
        cyc(1'b1, c_bad, 1'b0, "r_wb",     c_wb_r);

        // load, mem_ready low for 3 MEM cycles
        cyc(1'b1, c_bad,  1'b0, "ld_fetch",  c_fetch_rdy);
        cyc(1'b1, c_load, 1'b0, "ld_decode", c_none);
        cyc(1'b1, c_bad,  1'b0, "ld_exec",   c_exec_mem);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, c_bad, 1'b0, "ld_mem_wait", c_memread);
        cyc(1'b1, c_bad, 1'b0, "ld_mem_rdy", c_memread);
        cyc(1'b0, c_bad, 1'b0, "ld_wb",      c_wb_load);

        // store with one wait cycle, then branch
        cyc(1'b1, c_bad,   1'b0, "st_fetch",    c_fetch_rdy);
        cyc(1'b1, c_store, 1'b0, "st_decode",   c_none);
        cyc(1'b1, c_bad,   1'b0, "st_exec",     c_exec_mem);
        cyc(1'b0, c_bad,   1'b0, "st_mem_wait", c_memwrite);
        cyc(1'b1, c_bad,   1'b0, "st_mem_rdy",  c_store_done);
        do_branch();

        // JALR
        cyc(1'b1, c_bad,  1'b0, "jalr_fetch",  c_fetch_rdy);
        cyc(1'b1, c_jalr, 1'b0, "jalr_decode", c_none);
        cyc(1'b1, c_bad,  1'b0, "jalr_exec",   c_exec_jalr);
        cyc(1'b1, c_bad,  1'b0, "jalr_wb",     c_wb_jump);

        // unknown opcode
        cyc(1'b1, c_bad, 1'b0, "unk_fetch",  c_fetch_rdy);
        cyc(1'b1, c_bad, 1'b0, "unk_decode", c_none);
`ifdef TRAP_EN
        cyc(1'b1, c_bad, 1'b0, "unk_exec", c_none);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, c_bad, 1'b0, "unk_trap_hold", c_trap);
        cyc(1'b1, c_bad, 1'b1, "unk_trap_ack", c_trap);
`else
        cyc(1'b1, c_bad, 1'b0, "unk_exec_nop", c_exec_nop);
`endif

        // FETCH stall: timeout after 15 wait cycles, or unbounded wait
        for (int i = 0; i < 15; i++)
            cyc(1'b0, c_bad, 1'b0, "stall_fetch", c_memread);
`ifdef TRAP_EN
        cyc(1'b0, c_bad, 1'b1, "stall_trap", c_trap);
`else
        for (int i = 0; i < 5; i++)
            cyc(1'b0, c_bad, 1'b0, "stall_fetch_more", c_memread);
`endif
        do_branch();

        // asynchronous reset in the middle of a load's MEM phase
        cyc(1'b1, c_bad,  1'b0, "rst_fetch",  c_fetch_rdy);
        cyc(1'b1, c_load, 1'b0, "rst_decode", c_none);
        cyc(1'b1, c_bad,  1'b0, "rst_exec",   c_exec_mem);
        cyc(1'b0, c_bad,  1'b0, "rst_mem",    c_memread);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_async_outs", {19'b0, w_outs}, 32'd0);
        check("rst_async_cnt", {28'b0, bus.retired_cnt}, 32'd0);
        exp_cnt = 4'd0;
        pend    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_idle_outs", {19'b0, w_outs}, 32'd0);

        // 16 retirements wrap a 4-bit counter back to zero
        for (int i = 0; i < 16; i++)
            do_branch();
        cyc(1'b0, c_bad, 1'b0, "wrap_fetch", c_memread);
        check("wrap_zero", {28'b0, bus.retired_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
